// File: rtl/fpgc_bus_pkg.sv
// rtl/fpgc_bus_pkg.sv - shared types and constants for the SDRAM cache bus initiator.
package fpgc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } bus_state_e;

  localparam int DEFAULT_ADDR_BITS = 24;
  localparam int DEFAULT_DATA_BITS = 32;
  localparam int TMO_CNT_BITS      = 16;

endpackage

// File: rtl/sdram_bus_requester.sv
// rtl/sdram_bus_requester.sv - SDRAM cache bus initiator, one client transaction at a time.
// Optional macro SDRAM_REQ_TIMEOUT_EN bounds the WAIT state and reports expiry on client_err.
module sdram_bus_requester
  import fpgc_bus_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk100,
  input  logic                 reset,
  input  logic                 client_req,
  input  logic [ADDR_BITS-1:0] client_addr,
  input  logic                 client_we,
  input  logic [DATA_BITS-1:0] client_data,
  output logic                 client_accept,
  output logic                 client_busy,
  output logic [DATA_BITS-1:0] client_q,
  output logic                 client_done,
  output logic                 client_err,
  output logic [ADDR_BITS-1:0] bus_addr,
  output logic [DATA_BITS-1:0] bus_data,
  output logic                 bus_we,
  output logic                 bus_start,
  input  logic [DATA_BITS-1:0] bus_q,
  input  logic                 bus_done,
  input  logic                 bus_ready
);

  if (TIMEOUT < 1 || TIMEOUT >= (1 << TMO_CNT_BITS)) begin : g_bad_timeout
    $error("sdram_bus_requester: TIMEOUT does not fit the timeout counter");
  end

  bus_state_e             state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   we_q, we_d;
  logic                   accept_q, accept_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [DATA_BITS-1:0]   cq_q, cq_d;
  logic                   tmo_hit;

`ifdef SDRAM_REQ_TIMEOUT_EN
  localparam logic [TMO_CNT_BITS-1:0] TMO_LAST = TMO_CNT_BITS'(TIMEOUT - 1);

  logic [TMO_CNT_BITS-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter is zero whenever we are not waiting, so it starts clean on every WAIT entry.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_WAIT && !bus_done) begin
      tmo_cnt_d = tmo_cnt_q + TMO_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // A responder done on the expiry cycle wins over the timeout.
  assign tmo_hit = (state_q == ST_WAIT) && !bus_done && (tmo_cnt_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      accept_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cq_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      accept_q <= accept_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cq_q     <= cq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (client_req) state_d = ST_ISSUE;
      ST_ISSUE: if (bus_ready) state_d = ST_WAIT;
      ST_WAIT:  if (bus_done || tmo_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    accept_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cq_d     = cq_q;
    case (state_q)
      ST_IDLE: begin
        if (client_req) begin
          addr_d   = client_addr;
          data_d   = client_data;
          we_d     = client_we;
          accept_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus_done) begin
          if (!we_q) cq_d = bus_q;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (tmo_hit) begin
          done_d = 1'b1;
          err_d  = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus_start     = (state_q == ST_ISSUE) && bus_ready;
  assign bus_addr      = addr_q;
  assign bus_data      = data_q;
  assign bus_we        = we_q;
  assign client_accept = accept_q;
  assign client_busy   = busy_q;
  assign client_done   = done_q;
  assign client_err    = err_q;
  assign client_q      = cq_q;

endmodule

// File: tb/tb_sdram_bus_requester.sv
// tb/tb_sdram_bus_requester.sv - directed self-checking bench for sdram_bus_requester.
// Define SDRAM_REQ_TIMEOUT_EN to exercise the timeout build (TIMEOUT=8).
module tb_sdram_bus_requester;

  localparam int AB = 24;
  localparam int DB = 32;

  logic          clk100 = 1'b0;
  logic          reset = 1'b0;
  logic          client_req = 1'b0;
  logic [AB-1:0] client_addr = '0;
  logic          client_we = 1'b0;
  logic [DB-1:0] client_data = '0;
  logic          client_accept, client_busy, client_done, client_err;
  logic [DB-1:0] client_q;
  logic [AB-1:0] bus_addr;
  logic [DB-1:0] bus_data;
  logic          bus_we, bus_start;
  logic [DB-1:0] bus_q = '0;
  logic          bus_done = 1'b0;
  logic          bus_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  int resp_latency = 0;
  bit resp_never = 1'b0;
  int kick_req = 0;
  int kick_ack = 0;
  bit start_seen = 1'b0;
  bit resp_busy = 1'b0;
  int resp_cnt = 0;
  logic [AB-1:0] resp_addr = '0;

  sdram_bus_requester #(.ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(8)) dut (
    .clk100(clk100), .reset(reset),
    .client_req(client_req), .client_addr(client_addr), .client_we(client_we),
    .client_data(client_data), .client_accept(client_accept), .client_busy(client_busy),
    .client_q(client_q), .client_done(client_done), .client_err(client_err),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we), .bus_start(bus_start),
    .bus_q(bus_q), .bus_done(bus_done), .bus_ready(bus_ready)
  );

  always #5 clk100 = ~clk100;

  function automatic logic [DB-1:0] mem_word(input logic [AB-1:0] a);
    case (a)
      24'h000010: return 32'h12345678;
      24'h000001: return 32'h11110001;
      24'h000002: return 32'h22220002;
      default:    return {8'hD0, a};
    endcase
  endfunction

  always @(negedge clk100) start_seen = bus_start;

  // Responder: latency 0 puts done in the first WAIT cycle.
  always @(posedge clk100) begin
    #1;
    bus_done = 1'b0;
    bus_q = 32'hBAD0BAD0;
    if (start_seen && !resp_never) begin
      resp_busy = 1'b1;
      resp_cnt = resp_latency;
      resp_addr = bus_addr;
    end
    if (kick_req != kick_ack) begin
      kick_ack = kick_req;
      bus_done = 1'b1;
      bus_q = mem_word(bus_addr);
    end else if (resp_busy) begin
      if (resp_cnt == 0) begin
        bus_done = 1'b1;
        bus_q = mem_word(resp_addr);
        resp_busy = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
  end

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk100);
    checks++;
    if ({client_accept, client_busy, client_done, client_err, bus_start, bus_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000000",
               {client_accept, client_busy, client_done, client_err, bus_start, bus_we});
    end
    checks++;
    if (client_q !== 32'h0 || bus_addr !== 24'h0 || bus_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_words: got q=%h addr=%h data=%h expected all 0", client_q, bus_addr, bus_data);
    end
    reset = 1'b1;
    @(negedge clk100);
    checks++;
    if (client_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy: got %b expected 0", client_busy);
    end
  endtask

  task automatic test_zero_latency_read;
    resp_latency = 0;
    client_addr = 24'h10; client_we = 1'b0; client_data = 32'h0; client_req = 1'b1;
    @(negedge clk100);
    checks++;
    if ({client_accept, bus_start, client_busy} !== 3'b111 || bus_addr !== 24'h10) begin
      failures++;
      $display("FAIL zl_issue: got acc/start/busy=%b addr=%h expected 111 addr=000010",
               {client_accept, bus_start, client_busy}, bus_addr);
    end
    client_req = 1'b0;
    @(negedge clk100);
    checks++;
    if ({bus_start, client_done, client_accept} !== 3'b000) begin
      failures++;
      $display("FAIL zl_wait: got start/done/acc=%b expected 000", {bus_start, client_done, client_accept});
    end
    @(negedge clk100);
    checks++;
    if ({client_done, client_err, client_busy} !== 3'b100 || client_q !== 32'h12345678) begin
      failures++;
      $display("FAIL zl_done: got done/err/busy=%b q=%h expected 100 q=12345678",
               {client_done, client_err, client_busy}, client_q);
    end
    @(negedge clk100);
    checks++;
    if (client_done !== 1'b0) begin
      failures++;
      $display("FAIL zl_done_pulse: got %b expected 0", client_done);
    end
  endtask

  task automatic test_latency_write;
    int starts = 0;
    int unstable = 0;
    int done_off = -1;
    resp_latency = 5;
    client_addr = 24'h20; client_we = 1'b1; client_data = 32'hCAFEBABE; client_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk100);
      if (i == 0) begin
        client_req = 1'b0; client_addr = 24'h0; client_data = 32'h0; client_we = 1'b0;
      end
      if (bus_start) starts++;
      if (client_busy && (bus_we !== 1'b1 || bus_data !== 32'hCAFEBABE || bus_addr !== 24'h20))
        unstable++;
      if (client_done && done_off < 0) done_off = i;
    end
    checks++;
    if (starts != 1) begin
      failures++;
      $display("FAIL wr_starts: got %0d expected 1", starts);
    end
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL wr_bus_stable: got %0d unstable cycles expected 0", unstable);
    end
    checks++;
    if (done_off != 7) begin
      failures++;
      $display("FAIL wr_done_cycle: got %0d expected 7", done_off);
    end
    checks++;
    if (client_q !== 32'h12345678) begin
      failures++;
      $display("FAIL wr_q_held: got %h expected 12345678", client_q);
    end
  endtask

  task automatic test_ready_stall;
    int early_starts = 0;
    int idle_seen = 0;
    int done_off = -1;
    resp_latency = 0;
    bus_ready = 1'b0;
    client_addr = 24'h2; client_we = 1'b0; client_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk100);
      if (i == 0) client_req = 1'b0;
      if (bus_start) early_starts++;
      if (!client_busy) idle_seen++;
    end
    @(posedge clk100);
    #1 bus_ready = 1'b1;
    @(negedge clk100);
    checks++;
    if (early_starts != 0 || idle_seen != 0) begin
      failures++;
      $display("FAIL stall_hold: got starts=%0d idle=%0d expected 0 0", early_starts, idle_seen);
    end
    checks++;
    if (bus_start !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_start: got %b expected 1", bus_start);
    end
    for (int i = 1; i < 6 && done_off < 0; i++) begin
      @(negedge clk100);
      if (client_done) done_off = i;
    end
    checks++;
    if (done_off != 2 || client_q !== 32'h22220002) begin
      failures++;
      $display("FAIL stall_done: got off=%0d q=%h expected off=2 q=22220002", done_off, client_q);
    end
  endtask

  task automatic test_back_to_back;
    int accepts = 0, starts = 0, dones = 0, overlap = 0;
    logic [DB-1:0] q1 = '0, q2 = '0;
    resp_latency = 0;
    client_addr = 24'h1; client_we = 1'b0; client_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk100);
      if (bus_start) starts++;
      if (client_done && client_busy) overlap++;
      if (client_done) begin
        dones++;
        if (dones == 1) q1 = client_q;
        if (dones == 2) q2 = client_q;
      end
      if (client_accept) begin
        accepts++;
        if (accepts == 1) client_addr = 24'h2;
        if (accepts == 2) client_req = 1'b0;
      end
    end
    client_req = 1'b0;
    checks++;
    if (accepts != 2 || starts != 2 || dones != 2) begin
      failures++;
      $display("FAIL b2b_counts: got acc=%0d start=%0d done=%0d expected 2 2 2", accepts, starts, dones);
    end
    checks++;
    if (q1 !== 32'h11110001 || q2 !== 32'h22220002) begin
      failures++;
      $display("FAIL b2b_data: got %h,%h expected 11110001,22220002", q1, q2);
    end
    checks++;
    if (overlap != 0) begin
      failures++;
      $display("FAIL b2b_overlap: got %0d expected 0", overlap);
    end
  endtask

  task automatic test_reset_in_wait;
    int stray = 0, bad = 0, done_off = -1;
    resp_latency = 6;
    client_addr = 24'h10; client_we = 1'b0; client_req = 1'b1;
    @(negedge clk100);
    client_req = 1'b0;
    repeat (2) @(negedge clk100);
    reset = 1'b0;
    #1;
    checks++;
    if ({client_busy, client_accept, client_done, bus_start, bus_we} !== 5'b0 || bus_addr !== 24'h0
        || client_q !== 32'h0) begin
      failures++;
      $display("FAIL rst_wait_clear: got busy=%b start=%b addr=%h q=%h expected all 0",
               client_busy, bus_start, bus_addr, client_q);
    end
    repeat (2) @(negedge clk100);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk100);
      if (bus_done) stray++;
      if (client_done || client_busy || bus_start) bad++;
    end
    checks++;
    if (stray != 1 || bad != 0 || client_q !== 32'h0) begin
      failures++;
      $display("FAIL rst_stray_done: got stray=%0d bad=%0d q=%h expected 1 0 q=0", stray, bad, client_q);
    end
    resp_latency = 2;
    client_addr = 24'h1; client_req = 1'b1;
    for (int i = 0; i < 10 && done_off < 0; i++) begin
      @(negedge clk100);
      if (i == 0) client_req = 1'b0;
      if (client_done) done_off = i;
    end
    checks++;
    if (done_off != 4 || client_q !== 32'h11110001 || client_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_next_read: got off=%0d q=%h err=%b expected off=4 q=11110001 err=0",
               done_off, client_q, client_err);
    end
  endtask

`ifdef SDRAM_REQ_TIMEOUT_EN
  task automatic test_timeout;
    int done_off = -1;
    logic err_at = 1'b0;
    logic [DB-1:0] q_at = '0;
    resp_never = 1'b1;
    client_addr = 24'h3; client_we = 1'b0; client_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk100);
      if (i == 0) client_req = 1'b0;
      if (client_done && done_off < 0) begin
        done_off = i; err_at = client_err; q_at = client_q;
      end
    end
    resp_never = 1'b0;
    checks++;
    if (done_off != 9 || err_at !== 1'b1) begin
      failures++;
      $display("FAIL tmo_expiry: got off=%0d err=%b expected off=9 err=1", done_off, err_at);
    end
    checks++;
    if (q_at !== 32'h11110001 || client_busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_q_busy: got q=%h busy=%b expected 11110001 0", q_at, client_busy);
    end
    done_off = -1;
    resp_latency = 7;
    client_addr = 24'h10; client_req = 1'b1;
    for (int i = 0; i < 15 && done_off < 0; i++) begin
      @(negedge clk100);
      if (i == 0) client_req = 1'b0;
      if (client_done) begin
        done_off = i; err_at = client_err; q_at = client_q;
      end
    end
    checks++;
    if (done_off != 9 || err_at !== 1'b0 || q_at !== 32'h12345678) begin
      failures++;
      $display("FAIL tmo_done_priority: got off=%0d err=%b q=%h expected 9 0 12345678",
               done_off, err_at, q_at);
    end
  endtask
`else
  task automatic test_no_timeout;
    int early_done = 0, idle_seen = 0, done_off = -1;
    logic err_at = 1'b1;
    resp_never = 1'b1;
    client_addr = 24'h3; client_we = 1'b0; client_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk100);
      if (i == 0) client_req = 1'b0;
      if (client_done) early_done++;
      if (!client_busy) idle_seen++;
    end
    checks++;
    if (early_done != 0 || idle_seen != 0) begin
      failures++;
      $display("FAIL notmo_wait: got done=%0d idle=%0d expected 0 0", early_done, idle_seen);
    end
    kick_req++;
    for (int i = 0; i < 5 && done_off < 0; i++) begin
      @(negedge clk100);
      if (client_done) begin
        done_off = i; err_at = client_err;
      end
    end
    resp_never = 1'b0;
    checks++;
    if (done_off != 1 || err_at !== 1'b0 || client_q !== 32'hD0000003) begin
      failures++;
      $display("FAIL notmo_late_done: got off=%0d err=%b q=%h expected 1 0 D0000003",
               done_off, err_at, client_q);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_latency_read();
    test_latency_write();
    test_ready_stall();
    test_back_to_back();
    test_reset_in_wait();
`ifdef SDRAM_REQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_bus_requester.md
Name: sdram_bus_requester

Overview:
Initiator side of the SDRAM cache bus (addr/start/q/done/ready) that feeds the variable-latency memory responder. Accepts one client transaction at a time (read or write), waits for bus_ready, issues a single-cycle start, and waits any number of cycles for done. Returns read data and a one-cycle completion pulse to the client. Used in front of the L1 I-cache and L1 D-cache miss paths.

Parameters:
ADDR_BITS, 24, width of the bus address.
DATA_BITS, 32, width of the data, q and client words.
TIMEOUT, 255, WAIT-state cycle limit; used only when SDRAM_REQ_TIMEOUT_EN is defined.

Ports:
clk100  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
client_req  in  1  transaction request, level; sampled only in IDLE.
client_addr  in  ADDR_BITS  transaction address.
client_we  in  1  1 = write, 0 = read.
client_data  in  DATA_BITS  write data.
client_accept  out  1  one-cycle pulse: request latched.
client_busy  out  1  high from accept until client_done.
client_q  out  DATA_BITS  read data; valid from client_done, held until next read completes.
client_done  out  1  one-cycle pulse: transaction complete.
client_err  out  1  one-cycle pulse with client_done on timeout.
bus_addr  out  ADDR_BITS  registered address, stable from latch to completion.
bus_data  out  DATA_BITS  registered write data, stable from latch to completion.
bus_we  out  1  registered write flag, stable from latch to completion.
bus_start  out  1  request strobe to responder.
bus_q  in  DATA_BITS  responder read data; valid when bus_done=1.
bus_done  in  1  responder completion pulse.
bus_ready  in  1  responder can accept start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; client_q=0; timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If client_req=1: latch addr/data/we into bus_* registers, pulse client_accept, set client_busy, go to ISSUE.
  - bus_done in IDLE is ignored, including a stray done after a mid-operation reset.
- ISSUE:
  - bus_start = (state==ISSUE) & bus_ready. This is a combinational decode; it is high for exactly one cycle per transaction.
  - If bus_ready=1: go to WAIT at the edge. If bus_ready=0: stay in ISSUE with bus_start=0, indefinitely.
  - bus_done in ISSUE is ignored.
- WAIT:
  - bus_start=0.
  - On bus_done=1: if bus_we=0, client_q<=bus_q (client_q is unchanged for writes). Pulse client_done, clear client_busy, go to IDLE.
  - bus_done may arrive in the first WAIT cycle (zero-latency responder).
- Latency:
  - Edge E0 samples client_req. bus_start is high during E0–E1. The responder sets done during E1–E2.
  - client_done is high during E2–E3.
  - Minimum: 3 cycles request-sample to done; 4-cycle repeat rate. A client may hold client_req across client_done; the next accept occurs in the first IDLE cycle.
- bus_addr/bus_data/bus_we never change while client_busy=1.
- client_req and client_* inputs are ignored outside IDLE.

Optional Feature:
SDRAM_REQ_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without bus_done.
  - If it reaches TIMEOUT: pulse client_done and client_err together, leave client_q unchanged, go to IDLE.
  - bus_done on the same cycle as expiry takes priority: normal completion, client_err=0.
- Undefined: no counter; client_err tied to 0; WAIT waits forever.

Decomposition:
- Shared package fpgc_bus_pkg:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2).
  - Default ADDR_BITS and DATA_BITS constants.
  - Timeout counter width constant.
- No sub-module needed; the timeout counter stays inline, under the macro.

Test Plan:
- Zero-latency read: responder memory[0x10]=0x12345678, client read 0x10 → bus_start one cycle with bus_addr=0x10; client_done 3 cycles after req sampled; client_q=0x12345678; client_err=0.
- LATENCY=5 write: addr 0x20, data 0xCAFEBABE → bus_we=1 and bus_data stable through WAIT; exactly one bus_start; client_done after done; client_q unchanged.
- bus_ready held 0 for 7 cycles → stays in ISSUE, bus_start=0 throughout; start asserted in the first cycle ready=1.
- Back-to-back reads 0x1, 0x2 with req held high → two accepts, two starts, two done pulses; client_q 0x1 data then 0x2 data; no overlap of busy.
- Reset asserted in WAIT, responder later pulses done → outputs 0 immediately; the stray done is ignored; the next read completes correctly.
- SDRAM_REQ_TIMEOUT_EN, TIMEOUT=8, responder never done → client_done and client_err pulse together 8 WAIT cycles after start; FSM returns to IDLE.
